riscv_boot_loader: RTL and testbench
====================================

RISCV_BOOT_LOADER -- requirements
Module: riscv_boot_loader

Interface
REQ-001 Parameter ADDR_W, default 10: instruction-memory word-address width.
REQ-002 Parameter MAX_WORDS, default 1024: maximum words per load; SHALL satisfy MAX_WORDS <= 2^ADDR_W.
REQ-003 Parameter RST_HOLD, default 4: cycles cpu_reset stays high after the last write; SHALL be >= 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-006 start  input  1  begin a load; sampled in IDLE, RUN and ERROR only.
REQ-007 byte_valid  input  1  byte_data and byte_last are valid.
REQ-008 byte_data  input  8  program byte, little-endian within each word.
REQ-009 byte_last  input  1  marks the final byte of the image.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-012 imem_addr  output  ADDR_W  word address of the write.
REQ-013 imem_wdata  output  32  assembled instruction word.
REQ-014 cpu_reset  output  1  active-high reset to riscv_cpu; high = CPU held.
REQ-015 busy  output  1  high in LOAD, WRITE and HOLD.
REQ-016 done  output  1  high in RUN only.
REQ-017 error  output  1  high in ERROR only.
REQ-018 word_count  output  ADDR_W+1  number of words written in the current load.

Function
REQ-019 States SHALL be IDLE, LOAD, WRITE, HOLD, RUN and ERROR, with exactly one active per cycle.
REQ-020 IDLE: cpu_reset=1 and byte_ready=0; start=1 -> LOAD, clearing word_count, byte index and the assembly register.
REQ-021 LOAD: byte_ready=1; a byte is accepted on byte_valid&byte_ready and written to assembly lane byte_idx (lane 0 = bits 7:0); byte_idx then increments mod 4.
REQ-022 LOAD: acceptance of lane 3, or of any byte with byte_last=1, SHALL move to WRITE on the next cycle.
REQ-023 On byte_last, lanes above the accepted lane SHALL be written as zero.
REQ-024 WRITE lasts exactly one cycle: imem_we=1, imem_addr=word_count[ADDR_W-1:0], imem_wdata=assembly register, byte_ready=0.
REQ-025 After WRITE, word_count increments by 1, byte_idx clears and the assembly register clears.
REQ-026 After WRITE, the next state is HOLD if the word held the last byte, otherwise LOAD.
REQ-027 Overflow: if word_count==MAX_WORDS when a byte is accepted in LOAD, the state SHALL go to ERROR, the byte SHALL be discarded and no write SHALL occur.
REQ-028 HOLD: cpu_reset=1 and byte_ready=0; a counter SHALL run RST_HOLD cycles, then the state goes to RUN.
REQ-029 RUN: cpu_reset=0 and done=1; word_count SHALL stay frozen; start=1 -> LOAD, with cpu_reset high on the next cycle.
REQ-030 ERROR: cpu_reset=1, error=1 and byte_ready=0; the state persists until start=1 (-> LOAD, as in REQ-020) or reset.
REQ-031 start SHALL be ignored in LOAD, WRITE and HOLD.
REQ-032 byte_valid SHALL be ignored whenever byte_ready=0; no byte is lost or duplicated across WRITE.
REQ-033 imem_we SHALL be 0 in every state except WRITE.
REQ-034 imem_addr and imem_wdata SHALL hold their last values outside WRITE.
REQ-035 Every output SHALL be driven directly from registered state, with no combinational path from any input.

Reset
REQ-036 On reset=0, asynchronously: state=IDLE, cpu_reset=1, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, busy=0, done=0, error=0.
REQ-037 Reset asserted mid-LOAD or mid-HOLD SHALL abort the load with no further imem_we; the outputs SHALL match REQ-036.
REQ-038 After reset deasserts, the loader SHALL stay in IDLE until start=1.

Verification
REQ-039 Basic load: start, then bytes 13,00,50,00 with last on the 4th -> one WRITE with addr=0 and wdata=0x00500013, then 4 HOLD cycles, then RUN with cpu_reset=0 and word_count=1.
REQ-040 Partial word: 6 bytes 01..06 with last on byte 6 -> WRITEs with addr0=0x04030201 and addr1=0x00000605, word_count=2.
REQ-041 Backpressure gaps: byte_valid toggled randomly over 8 bytes -> exactly 2 writes with correct data; byte_ready=0 during each WRITE cycle.
REQ-042 Overflow: MAX_WORDS=2 with 9 bytes -> 2 writes, then ERROR with error=1 and cpu_reset=1; a later start returns to LOAD with word_count=0.
REQ-043 Reset mid-load: reset=0 after 2 bytes -> immediate IDLE values; a new load writes from addr 0 with no stale lane data.
REQ-044 Reload from RUN: start in RUN -> cpu_reset=1 on the next cycle and a new image is written from addr 0.

Source files
------------

// File: rtl/riscv_boot_loader.sv
// Byte-stream boot loader: packs little-endian bytes into 32-bit words, writes them to
// instruction memory, then holds the CPU in reset for RST_HOLD cycles before releasing it.
module riscv_boot_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  input  logic              byte_last_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int unsigned CntW  = ADDR_W + 1;
  localparam int unsigned HoldW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CntW-1:0]  MaxWords = CntW'(MAX_WORDS);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StHold,
    StRun,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       asm_q, asm_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              last_q, last_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_fill;

  // Assembly register with the incoming byte merged in; on the final byte the lanes
  // above it are forced to zero.
  always_comb begin
    asm_fill = asm_q;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == byte_idx_q) begin
        asm_fill[8*i +: 8] = byte_data_i;
      end else if (byte_last_i && (2'(i) > byte_idx_q)) begin
        asm_fill[8*i +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    count_d    = count_q;
    last_d     = last_q;
    hold_d     = hold_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      StIdle, StRun, StError: begin
        if (start_i) begin
          state_d    = StLoad;
          count_d    = '0;
          byte_idx_d = '0;
          asm_d      = '0;
          last_d     = 1'b0;
        end
      end
      StLoad: begin
        if (byte_valid_i) begin
          if (count_q == MaxWords) begin
            // Image larger than the memory window: drop the byte, no write.
            state_d = StError;
          end else begin
            asm_d      = asm_fill;
            byte_idx_d = byte_idx_q + 2'd1;
            last_d     = byte_last_i;
            if ((byte_idx_q == 2'd3) || byte_last_i) begin
              state_d = StWrite;
              addr_d  = count_q[ADDR_W-1:0];
              wdata_d = asm_fill;
            end
          end
        end
      end
      StWrite: begin
        count_d    = count_q + 1'b1;
        byte_idx_d = '0;
        asm_d      = '0;
        hold_d     = '0;
        last_d     = 1'b0;
        state_d    = last_q ? StHold : StLoad;
      end
      StHold: begin
        if (hold_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      byte_idx_q <= '0;
      asm_q      <= '0;
      count_q    <= '0;
      last_q     <= 1'b0;
      hold_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      count_q    <= count_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign byte_ready_o = (state_q == StLoad);
  assign imem_we_o    = (state_q == StWrite);
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_reset_o  = (state_q != StRun);
  assign busy_o       = (state_q == StLoad) || (state_q == StWrite) || (state_q == StHold);
  assign done_o       = (state_q == StRun);
  assign error_o      = (state_q == StError);
  assign word_count_o = count_q;

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Directed bench for riscv_boot_loader: table of whole-image loads plus hand sequences
// for overflow and reset during a load.
module tb_riscv_boot_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_last;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  riscv_boot_loader #(
    .ADDR_W   (ADDR_W),
    .MAX_WORDS(2),
    .RST_HOLD (4)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .byte_valid_i(byte_valid),
    .byte_data_i (byte_data),
    .byte_last_i (byte_last),
    .byte_ready_o(byte_ready),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wdata_o(imem_wdata),
    .cpu_reset_o (cpu_reset),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: logs every memory write; the loader must not take bytes while writing.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
      check("ready_low_in_write", 64'(byte_ready), 64'd0);
    end
  end

  typedef struct packed {
    logic [3:0]  n;      // byte count
    logic [63:0] bytes;  // byte i at bits 8*i+7:8*i
    logic [7:0]  gap;    // bit i: one idle cycle before byte i
    logic [1:0]  nw;     // expected writes
    logic [63:0] words;  // word i at bits 32*i+31:32*i
  } vec_t;

  vec_t vecs[5];

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    logic got;
    got        = 1'b0;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = last;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (byte_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    check("byte_accept_timeout", 64'(got), 64'd1);
  endtask

  // Negedges from the just-entered WRITE until done: 1 WRITE + 4 HOLD -> 5.
  task automatic wait_done(output int cycles);
    cycles = 60;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_imem_we"}, 64'(imem_we), 64'd0);
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] ew;

    vecs[0] = '{n: 4'd4, bytes: 64'h00000000_00500013, gap: 8'h00, nw: 2'd1,
                words: 64'h00000000_00500013};
    vecs[1] = '{n: 4'd6, bytes: 64'h00000605_04030201, gap: 8'h00, nw: 2'd2,
                words: 64'h00000605_04030201};
    vecs[2] = '{n: 4'd8, bytes: 64'h88776655_44332211, gap: 8'b1011_0101, nw: 2'd2,
                words: 64'h88776655_44332211};
    vecs[3] = '{n: 4'd1, bytes: 64'h00000000_000000ab, gap: 8'b0000_0001, nw: 2'd1,
                words: 64'h00000000_000000ab};
    vecs[4] = '{n: 4'd5, bytes: 64'h000000ee_ddccbbaa, gap: 8'b0001_0010, nw: 2'd2,
                words: 64'h000000ee_ddccbbaa};

    rst_n      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_stays_busy", 64'(busy), 64'd0);
    check("idle_stays_ready", 64'(byte_ready), 64'd0);
    check("idle_stays_cpu_reset", 64'(cpu_reset), 64'd1);

    // Table of complete loads; every load after the first starts from RUN.
    for (int v = 0; v < 5; v++) begin
      wr_addr.delete();
      wr_data.delete();
      pulse_start();
      @(negedge clk);
      check($sformatf("v%0d_load_cpu_reset", v), 64'(cpu_reset), 64'd1);
      check($sformatf("v%0d_load_ready", v), 64'(byte_ready), 64'd1);
      check($sformatf("v%0d_load_count", v), 64'(word_count), 64'd0);
      @(posedge clk); #1;
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        if (vecs[v].gap[i]) begin
          @(posedge clk); #1;
        end
        send_byte(vecs[v].bytes[8*i +: 8], (i == int'(vecs[v].n) - 1));
      end
      wait_done(cyc);
      check($sformatf("v%0d_hold_cycles", v), 64'(cyc), 64'd5);
      check($sformatf("v%0d_nwrites", v), 64'(wr_addr.size()), 64'(vecs[v].nw));
      for (int w = 0; w < int'(vecs[v].nw) && w < wr_addr.size(); w++) begin
        check($sformatf("v%0d_addr%0d", v, w), 64'(wr_addr[w]), 64'(w));
        check($sformatf("v%0d_data%0d", v, w), 64'(wr_data[w]), 64'(vecs[v].words[32*w +: 32]));
      end
      check($sformatf("v%0d_run_cpu_reset", v), 64'(cpu_reset), 64'd0);
      check($sformatf("v%0d_run_count", v), 64'(word_count), 64'(vecs[v].nw));
      ew = vecs[v].words[32*(int'(vecs[v].nw) - 1) +: 32];
      check($sformatf("v%0d_held_wdata", v), 64'(imem_wdata), 64'(ew));
      check($sformatf("v%0d_held_addr", v), 64'(imem_addr), 64'(int'(vecs[v].nw) - 1));
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_run_frozen", v), 64'(word_count), 64'(vecs[v].nw));
      check($sformatf("v%0d_run_done", v), 64'(done), 64'd1);
      @(posedge clk); #1;
    end

    // Overflow: MAX_WORDS=2, nine bytes with none marked last.
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h21 + 8'(i), 1'b0);
    end
    @(negedge clk);
    check("ovf_nwrites", 64'(wr_addr.size()), 64'd2);
    if (wr_data.size() >= 2) begin
      check("ovf_data0", 64'(wr_data[0]), 64'h24232221);
      check("ovf_data1", 64'(wr_data[1]), 64'h28272625);
    end
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_cpu_reset", 64'(cpu_reset), 64'd1);
    check("ovf_ready", 64'(byte_ready), 64'd0);
    check("ovf_busy", 64'(busy), 64'd0);
    check("ovf_count", 64'(word_count), 64'd2);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_data  = 8'h99;
    repeat (3) @(posedge clk);
    #1 byte_valid = 1'b0;
    @(negedge clk);
    check("err_persist", 64'(error), 64'd1);
    check("err_no_write", 64'(wr_addr.size()), 64'd2);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    check("err_restart_ready", 64'(byte_ready), 64'd1);
    check("err_restart_error", 64'(error), 64'd0);
    check("err_restart_count", 64'(word_count), 64'd0);
    @(posedge clk); #1;

    // Reset with two bytes assembled; the next image must not see them.
    send_byte(8'hff, 1'b0);
    send_byte(8'hee, 1'b0);
    rst_n = 1'b0;
    #1 check_idle_reset("midload");
    wr_addr.delete();
    wr_data.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("after_reset_idle", 64'(busy), 64'd0);
    pulse_start();
    send_byte(8'h5a, 1'b1);
    wait_done(cyc);
    check("rl_hold_cycles", 64'(cyc), 64'd5);
    check("rl_nwrites", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() >= 1) begin
      check("rl_addr0", 64'(wr_addr[0]), 64'd0);
      check("rl_data0", 64'(wr_data[0]), 64'h0000005a);
    end
    check("rl_count", 64'(word_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
